// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

   // Receiver FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   // Default terminator word that ends a programming session
   localparam logic [63:0] DEFAULT_END_MARKER = 64'h0000_0000_0000_0FFF;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// Bit-level 8N1 UART receiver: 2-flop synchronizer, start-bit glitch
// rejection, mid-bit sampling, one-cycle byte valid / frame error pulses.
module uart_rx_byte
   import uart_prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int                TMR_W   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TMR_W-1:0] HALF    = TMR_W'(CLKS_PER_BIT / 2);
   localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);

   logic [1:0]       sync_r;
   logic             prev_r;
   logic             rx_s;
   rx_state_t        state_r;
   rx_state_t        state_nxt_s;
   logic [TMR_W-1:0] tmr_r;
   logic [2:0]       bit_r;
   logic [7:0]       shift_r;
   logic             tmr_clr_s;
   logic             shift_s;
   logic             stop_s;
   logic [7:0]       data_r;
   logic             valid_r;
   logic             ferr_r;

   assign rx_s = sync_r[1];

   // Two-flop synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= 2'b11;
         prev_r <= 1'b1;
      end else begin
         sync_r <= {sync_r[0], rx};
         prev_r <= sync_r[1];
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (prev_r && !rx_s) state_nxt_s = ST_START;
            else                 state_nxt_s = ST_IDLE;
         end
         ST_START: begin
            if (tmr_r == HALF) state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
            else               state_nxt_s = ST_START;
         end
         ST_DATA: begin
            if (tmr_r == FULL_M1 && bit_r == 3'd7) state_nxt_s = ST_STOP;
            else                                   state_nxt_s = ST_DATA;
         end
         ST_STOP: begin
            if (tmr_r == FULL_M1) state_nxt_s = ST_IDLE;
            else                  state_nxt_s = ST_STOP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM control outputs: timer clear, data-bit shift, stop-bit sample
   always_comb begin
      tmr_clr_s = 1'b0;
      shift_s   = 1'b0;
      stop_s    = 1'b0;
      case (state_r)
         ST_IDLE:  tmr_clr_s = 1'b1;
         ST_START: tmr_clr_s = (tmr_r == HALF);
         ST_DATA: begin
            shift_s   = (tmr_r == FULL_M1);
            tmr_clr_s = (tmr_r == FULL_M1);
         end
         ST_STOP: begin
            stop_s    = (tmr_r == FULL_M1);
            tmr_clr_s = (tmr_r == FULL_M1);
         end
         default: tmr_clr_s = 1'b1;
      endcase
   end

   // Bit timer, bit counter and LSB-first shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_r   <= '0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
      end else begin
         tmr_r <= tmr_clr_s ? '0 : tmr_r + TMR_W'(1);
         if (shift_s) begin
            bit_r   <= bit_r + 3'd1;
            shift_r <= {rx_s, shift_r[7:1]};
         end
      end
   end

   // Registered byte output with one-cycle valid / frame-error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r  <= 8'h00;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
      end else begin
         valid_r <= stop_s & rx_s;
         ferr_r  <= stop_s & ~rx_s;
         if (stop_s && rx_s) data_r <= shift_r;
      end
   end

   assign data      = data_r;
   assign valid     = valid_r;
   assign frame_err = ferr_r;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: assembles received bytes into little-endian words
// and writes them to instruction memory until the terminator word arrives.
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int                      CLKS_PER_BIT = 21,
   parameter int                      WORD_BYTES   = 8,
   parameter int                      ADDR_W       = 10,
   parameter logic [8*WORD_BYTES-1:0] END_MARKER   = (8*WORD_BYTES)'(DEFAULT_END_MARKER)
) (
   input  logic                      clk_in1,
   input  logic                      rst,
   input  logic                      uart_rx_i,
   output logic                      we_o,
   output logic [ADDR_W-1:0]         addr_o,
   output logic [8*WORD_BYTES-1:0]   wdata_o,
   output logic                      programmed_o,
   output logic                      frame_err_o,
   output logic [ADDR_W:0]           word_cnt_o
);

   localparam int                 WORD_W    = 8 * WORD_BYTES;
   localparam int                 LANE_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

   logic [7:0]        rx_data_s;
   logic              rx_valid_s;
   logic              rx_ferr_s;
   logic              byte_ok_s;
   logic              ferr_ok_s;
   logic              word_done_s;
   logic              is_end_s;
   logic [WORD_W-1:0] completed_s;
   logic [WORD_W-1:0] word_r;
   logic [LANE_W-1:0] lane_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [WORD_W-1:0] wdata_r;
   logic              prog_r;
   logic              ferr_r;
   logic [ADDR_W:0]   cnt_r;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk_in1),
      .rst       (rst),
      .rx        (uart_rx_i),
      .data      (rx_data_s),
      .valid     (rx_valid_s),
      .frame_err (rx_ferr_s)
   );

   // Once programmed, the receiver's output is ignored completely
   assign byte_ok_s = rx_valid_s & ~prog_r;
   assign ferr_ok_s = rx_ferr_s & ~prog_r;

   // Word as it looks with the incoming byte placed in the top lane
   always_comb begin
      completed_s                   = word_r;
      completed_s[WORD_W-1 -: 8]    = rx_data_s;
      word_done_s                   = byte_ok_s && (lane_r == LAST_LANE);
      is_end_s                      = (completed_s == END_MARKER);
   end

   // Byte-lane fill; lane index only moves on accepted bytes
   always_ff @(posedge clk_in1 or posedge rst) begin
      if (rst) begin
         word_r <= '0;
         lane_r <= '0;
      end else if (byte_ok_s) begin
         word_r[{lane_r, 3'b000} +: 8] <= rx_data_s;
         lane_r <= word_done_s ? '0 : lane_r + LANE_W'(1);
      end
   end

   // Memory write strobe, address / count advance after the strobe, sticky flags
   always_ff @(posedge clk_in1 or posedge rst) begin
      if (rst) begin
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         prog_r  <= 1'b0;
         ferr_r  <= 1'b0;
         cnt_r   <= '0;
      end else begin
         we_r <= word_done_s & ~is_end_s;
         if (word_done_s && !is_end_s) wdata_r <= completed_s;
         if (word_done_s && is_end_s)  prog_r  <= 1'b1;
         if (ferr_ok_s)                ferr_r  <= 1'b1;
         if (we_r) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (cnt_r != CNT_MAX) cnt_r <= cnt_r + (ADDR_W+1)'(1);
         end
      end
   end

   assign we_o         = we_r;
   assign addr_o       = addr_r;
   assign wdata_o      = wdata_r;
   assign programmed_o = prog_r;
   assign frame_err_o  = ferr_r;
   assign word_cnt_o   = cnt_r;

endmodule
